// File: rtl/signed_div_pkg.sv
// Shared types and constants for the iterative signed divider.
package signed_div_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      FIX  = 2'd2,
      DONE = 2'd3
   } state_e;

   // Step counter must hold values up to 2*width.
   function automatic int cnt_width(input int width);
      return $clog2(2 * width) + 1;
   endfunction

   // Most-negative (neg=1) or most-positive (neg=0) value of a w-bit signed number,
   // returned right-aligned in 64 bits.
   function automatic logic [63:0] sat_val(input int w, input logic neg);
      logic [63:0] msb;
      msb = 64'd1 << (w - 1);
      return neg ? msb : (msb - 64'd1);
   endfunction

   localparam int DEF_WIDTH = 8;
   localparam int DEF_CNT_W = cnt_width(DEF_WIDTH);

endpackage

// File: rtl/signed_divider.sv
// Iterative signed divider: 2*WIDTH / WIDTH -> 2*WIDTH quotient, WIDTH remainder.
// Magnitudes are taken on the accepting edge, then one restoring shift-subtract
// step per cycle, then a single cycle applies signs and saturation.
module signed_divider
   import signed_div_pkg::*;
#(
   parameter int WIDTH                 = 8,
   parameter int CONTROL_SIGNALS_WIDTH = 8
) (
   input  logic                             clk,
   input  logic                             rst,
   input  logic                             in_valid,
   output logic                             in_ready,
   input  logic [2*WIDTH-1:0]               dividend,
   input  logic [WIDTH-1:0]                 divisor,
   input  logic [CONTROL_SIGNALS_WIDTH-1:0] control_signals_in,
   output logic                             out_valid,
   input  logic                             out_ready,
   output logic [2*WIDTH-1:0]               quotient,
   output logic [WIDTH-1:0]                 remainder,
   output logic                             overflow,
   output logic                             div_by_zero,
   output logic [CONTROL_SIGNALS_WIDTH-1:0] control_signals_out
);

   localparam int W2    = 2 * WIDTH;
   localparam int CNT_W = cnt_width(WIDTH);

   localparam logic [63:0]      MAX64    = sat_val(W2, 1'b0);
   localparam logic [63:0]      MIN64    = sat_val(W2, 1'b1);
   localparam logic [W2-1:0]    Q_MAX    = MAX64[W2-1:0];
   localparam logic [W2-1:0]    Q_MIN    = MIN64[W2-1:0];
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(W2 - 1);

   state_e                           state_q, state_d;
   logic [CNT_W-1:0]                 cnt_q, cnt_d;
   // work_q holds |dividend| and gradually fills with quotient bits from the LSB.
   logic [W2-1:0]                    work_q, work_d;
   logic [WIDTH-1:0]                 rem_q, rem_d;
   logic [WIDTH-1:0]                 dvs_q, dvs_d;
   logic                             qneg_q, qneg_d;
   logic                             rneg_q, rneg_d;
   logic [CONTROL_SIGNALS_WIDTH-1:0] tag_q, tag_d;
   logic [W2-1:0]                    quot_q, quot_d;
   logic [WIDTH-1:0]                 remo_q, remo_d;
   logic                             ovf_q, ovf_d;
   logic                             dbz_q, dbz_d;
   logic [CONTROL_SIGNALS_WIDTH-1:0] ctrl_q, ctrl_d;

   logic [WIDTH:0] trial;
   logic [WIDTH:0] diff;

   assign in_ready            = (state_q == IDLE);
   assign out_valid           = (state_q == DONE);
   assign quotient            = quot_q;
   assign remainder           = remo_q;
   assign overflow            = ovf_q;
   assign div_by_zero         = dbz_q;
   assign control_signals_out = ctrl_q;

   // Next-state, datapath step and output formation.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      work_d  = work_q;
      rem_d   = rem_q;
      dvs_d   = dvs_q;
      qneg_d  = qneg_q;
      rneg_d  = rneg_q;
      tag_d   = tag_q;
      quot_d  = quot_q;
      remo_d  = remo_q;
      ovf_d   = ovf_q;
      dbz_d   = dbz_q;
      ctrl_d  = ctrl_q;

      // Partial remainder stays below |divisor| <= 2^(WIDTH-1), so the shifted
      // trial fits WIDTH bits and diff[WIDTH] is a clean borrow flag.
      trial = {rem_q, work_q[W2-1]};
      diff  = trial - {1'b0, dvs_q};

      unique case (state_q)
         IDLE: begin
            if (in_valid) begin
               ovf_d  = 1'b0;
               dbz_d  = 1'b0;
               tag_d  = control_signals_in;
               qneg_d = dividend[W2-1] ^ divisor[WIDTH-1];
               rneg_d = dividend[W2-1];
               work_d = dividend[W2-1] ? (~dividend + 1'b1) : dividend;
               dvs_d  = divisor[WIDTH-1] ? (~divisor + 1'b1) : divisor;
               rem_d  = '0;
               cnt_d  = '0;
               if (divisor == '0) begin
                  dbz_d   = 1'b1;
                  quot_d  = dividend[W2-1] ? Q_MIN : Q_MAX;
                  remo_d  = '0;
                  ctrl_d  = control_signals_in;
                  state_d = DONE;
               end else begin
                  state_d = CALC;
               end
            end
         end
         CALC: begin
            if (!diff[WIDTH]) begin
               rem_d  = diff[WIDTH-1:0];
               work_d = {work_q[W2-2:0], 1'b1};
            end else begin
               rem_d  = trial[WIDTH-1:0];
               work_d = {work_q[W2-2:0], 1'b0};
            end
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == CNT_LAST) state_d = FIX;
         end
         FIX: begin
            // A positive quotient with the MSB set can only be 2^(W2-1): MIN / -1.
            if (!qneg_q && work_q[W2-1]) begin
               quot_d = Q_MAX;
               ovf_d  = 1'b1;
            end else begin
               quot_d = qneg_q ? (~work_q + 1'b1) : work_q;
            end
            remo_d  = rneg_q ? (~rem_q + 1'b1) : rem_q;
            ctrl_d  = tag_q;
            state_d = DONE;
         end
         DONE: begin
            if (out_ready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // State and datapath registers with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         work_q  <= '0;
         rem_q   <= '0;
         dvs_q   <= '0;
         qneg_q  <= 1'b0;
         rneg_q  <= 1'b0;
         tag_q   <= '0;
         quot_q  <= '0;
         remo_q  <= '0;
         ovf_q   <= 1'b0;
         dbz_q   <= 1'b0;
         ctrl_q  <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         work_q  <= work_d;
         rem_q   <= rem_d;
         dvs_q   <= dvs_d;
         qneg_q  <= qneg_d;
         rneg_q  <= rneg_d;
         tag_q   <= tag_d;
         quot_q  <= quot_d;
         remo_q  <= remo_d;
         ovf_q   <= ovf_d;
         dbz_q   <= dbz_d;
         ctrl_q  <= ctrl_d;
      end
   end

endmodule

// File: tb/tb_signed_divider.sv
// Directed self-checking bench for signed_divider (WIDTH=8, tag width 8).
module tb_signed_divider;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [15:0] dividend = '0;
   logic [7:0]  divisor = '0;
   logic [7:0]  control_signals_in = '0;
   logic        out_valid;
   logic        out_ready = 1'b0;
   logic [15:0] quotient;
   logic [7:0]  remainder;
   logic        overflow;
   logic        div_by_zero;
   logic [7:0]  control_signals_out;

   int n_pass  = 0;
   int n_total = 0;

   signed_divider #(.WIDTH(8), .CONTROL_SIGNALS_WIDTH(8)) dut (
      .clk                 (clk),
      .rst                 (rst),
      .in_valid            (in_valid),
      .in_ready            (in_ready),
      .dividend            (dividend),
      .divisor             (divisor),
      .control_signals_in  (control_signals_in),
      .out_valid           (out_valid),
      .out_ready           (out_ready),
      .quotient            (quotient),
      .remainder           (remainder),
      .overflow            (overflow),
      .div_by_zero         (div_by_zero),
      .control_signals_out (control_signals_out)
   );

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
      $fatal(1, "watchdog");
   end

   // Offer one operation, wait for acceptance, then wait for out_valid.
   // lat counts clock edges from the accepting edge (inclusive) until out_valid is seen.
   task automatic issue(input int a, input int b, input int t, output int lat);
      @(negedge clk);
      in_valid           = 1'b1;
      dividend           = 16'(a);
      divisor            = 8'(b);
      control_signals_in = 8'(t);
      for (int i = 0; i < 50 && !in_ready; i++) @(negedge clk);
      @(posedge clk); #1;
      in_valid           = 1'b0;
      dividend           = 16'hA5A5;
      divisor            = 8'h3C;
      control_signals_in = 8'hEE;
      lat = 1;
      while (!out_valid && lat < 100) begin
         @(posedge clk); #1;
         lat++;
      end
   endtask

   task automatic release_result();
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      n_total++; if (in_ready !== 1'b1) $display("FAIL reset_in_ready: got %b expected 1", in_ready); else n_pass++;
      n_total++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid: got %b expected 0", out_valid); else n_pass++;
      n_total++; if (quotient !== 16'h0) $display("FAIL reset_quotient: got %h expected 0", quotient); else n_pass++;
      n_total++; if (remainder !== 8'h0) $display("FAIL reset_remainder: got %h expected 0", remainder); else n_pass++;
      n_total++; if (overflow !== 1'b0) $display("FAIL reset_overflow: got %b expected 0", overflow); else n_pass++;
      n_total++; if (div_by_zero !== 1'b0) $display("FAIL reset_dbz: got %b expected 0", div_by_zero); else n_pass++;
      n_total++; if (control_signals_out !== 8'h0) $display("FAIL reset_tag: got %h expected 0", control_signals_out); else n_pass++;
      rst = 1'b1;
   endtask

   task automatic test_basic();
      int lat;
      issue(-1000, 7, 8'h05, lat);
      n_total++; if (lat !== 18) $display("FAIL basic_latency: got %0d expected 18", lat); else n_pass++;
      n_total++; if (quotient !== 16'(-142)) $display("FAIL basic_quotient: got %0d expected -142", $signed(quotient)); else n_pass++;
      n_total++; if (remainder !== 8'(-6)) $display("FAIL basic_remainder: got %0d expected -6", $signed(remainder)); else n_pass++;
      n_total++; if (overflow !== 1'b0) $display("FAIL basic_overflow: got %b expected 0", overflow); else n_pass++;
      n_total++; if (div_by_zero !== 1'b0) $display("FAIL basic_dbz: got %b expected 0", div_by_zero); else n_pass++;
      n_total++; if (control_signals_out !== 8'h05) $display("FAIL basic_tag: got %h expected 05", control_signals_out); else n_pass++;
      n_total++; if (in_ready !== 1'b0) $display("FAIL basic_in_ready_done: got %b expected 0", in_ready); else n_pass++;
      release_result();
      n_total++; if (out_valid !== 1'b0) $display("FAIL basic_out_valid_drop: got %b expected 0", out_valid); else n_pass++;
   endtask

   task automatic test_reset_mid_calc();
      bit seen = 1'b0;
      int lat;
      @(negedge clk);
      in_valid = 1'b1; dividend = 16'd1000; divisor = 8'd7; control_signals_in = 8'h77;
      @(posedge clk); #1;
      in_valid = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk); #1;
      n_total++; if (in_ready !== 1'b1) $display("FAIL midrst_in_ready: got %b expected 1", in_ready); else n_pass++;
      n_total++; if (out_valid !== 1'b0) $display("FAIL midrst_out_valid: got %b expected 0", out_valid); else n_pass++;
      n_total++;
      if (quotient !== 16'h0 || remainder !== 8'h0 || overflow !== 1'b0 || div_by_zero !== 1'b0 || control_signals_out !== 8'h0)
         $display("FAIL midrst_outputs: got q=%h r=%h ovf=%b dbz=%b tag=%h expected all 0",
                  quotient, remainder, overflow, div_by_zero, control_signals_out);
      else n_pass++;
      @(negedge clk);
      rst = 1'b1;
      for (int i = 0; i < 30; i++) begin
         @(posedge clk); #1;
         if (out_valid) seen = 1'b1;
      end
      n_total++; if (seen !== 1'b0) $display("FAIL midrst_no_result: got out_valid=1 expected never"); else n_pass++;
      // Bench keeps going only if the block still works after the abort.
      issue(20, 3, 8'h21, lat);
      n_total++; if (quotient !== 16'd6 || remainder !== 8'd2) $display("FAIL midrst_after: got q=%0d r=%0d expected q=6 r=2", $signed(quotient), $signed(remainder)); else n_pass++;
      release_result();
   endtask

   task automatic test_mixed_signs();
      int lat;
      issue(32767, -128, 8'h11, lat);
      n_total++; if (quotient !== 16'(-255)) $display("FAIL mixed1_quotient: got %0d expected -255", $signed(quotient)); else n_pass++;
      n_total++; if (remainder !== 8'd127) $display("FAIL mixed1_remainder: got %0d expected 127", $signed(remainder)); else n_pass++;
      release_result();
      issue(-7, 2, 8'h12, lat);
      n_total++; if (quotient !== 16'(-3)) $display("FAIL mixed2_quotient: got %0d expected -3", $signed(quotient)); else n_pass++;
      n_total++; if (remainder !== 8'(-1)) $display("FAIL mixed2_remainder: got %0d expected -1", $signed(remainder)); else n_pass++;
      n_total++; if (control_signals_out !== 8'h12) $display("FAIL mixed2_tag: got %h expected 12", control_signals_out); else n_pass++;
      release_result();
   endtask

   task automatic test_overflow();
      int lat;
      issue(-32768, -1, 8'h33, lat);
      n_total++; if (quotient !== 16'd32767) $display("FAIL ovf_quotient: got %0d expected 32767", $signed(quotient)); else n_pass++;
      n_total++; if (remainder !== 8'd0) $display("FAIL ovf_remainder: got %0d expected 0", $signed(remainder)); else n_pass++;
      n_total++; if (overflow !== 1'b1) $display("FAIL ovf_flag: got %b expected 1", overflow); else n_pass++;
      n_total++; if (div_by_zero !== 1'b0) $display("FAIL ovf_dbz: got %b expected 0", div_by_zero); else n_pass++;
      release_result();
   endtask

   task automatic test_div_by_zero();
      int lat;
      issue(100, 0, 8'h44, lat);
      n_total++; if (lat !== 1) $display("FAIL dbz_latency: got %0d expected 1", lat); else n_pass++;
      n_total++; if (quotient !== 16'd32767) $display("FAIL dbz_pos_quotient: got %0d expected 32767", $signed(quotient)); else n_pass++;
      n_total++; if (remainder !== 8'd0) $display("FAIL dbz_remainder: got %0d expected 0", $signed(remainder)); else n_pass++;
      n_total++; if (div_by_zero !== 1'b1) $display("FAIL dbz_flag: got %b expected 1", div_by_zero); else n_pass++;
      n_total++; if (overflow !== 1'b0) $display("FAIL dbz_overflow: got %b expected 0", overflow); else n_pass++;
      n_total++; if (control_signals_out !== 8'h44) $display("FAIL dbz_tag: got %h expected 44", control_signals_out); else n_pass++;
      release_result();
      issue(-5, 0, 8'h45, lat);
      n_total++; if (quotient !== 16'h8000) $display("FAIL dbz_neg_quotient: got %0d expected -32768", $signed(quotient)); else n_pass++;
      release_result();
   endtask

   task automatic test_back_to_back();
      int a_t [10] = '{1000, -1000, 12345, -32768, 32767, -32767, 0, 5, -300, -32768};
      int b_t [10] = '{10, 10, -100, 1, 127, -128, -5, 7, 0, -128};
      int q_t [10] = '{100, -100, -123, -32768, 258, 255, 0, 0, -32768, 256};
      int r_t [10] = '{0, 0, 45, 0, 1, -127, 0, 5, 0, 0};
      int lat;
      logic [15:0] hq;
      logic [7:0]  hr, ht;
      for (int i = 0; i < 10; i++) begin
         issue(a_t[i], b_t[i], i + 1, lat);
         n_total++;
         if (quotient !== 16'(q_t[i]) || remainder !== 8'(r_t[i]) || control_signals_out !== 8'(i + 1))
            $display("FAIL b2b_op%0d: got q=%0d r=%0d tag=%0d expected q=%0d r=%0d tag=%0d",
                     i + 1, $signed(quotient), $signed(remainder), control_signals_out, q_t[i], r_t[i], i + 1);
         else n_pass++;
         n_total++;
         if (div_by_zero !== (b_t[i] == 0) || overflow !== 1'b0 || lat !== ((b_t[i] == 0) ? 1 : 18))
            $display("FAIL b2b_flags_op%0d: got dbz=%b ovf=%b lat=%0d expected dbz=%b ovf=0 lat=%0d",
                     i + 1, div_by_zero, overflow, lat, (b_t[i] == 0), (b_t[i] == 0) ? 1 : 18);
         else n_pass++;
         if (i == 2) begin
            hq = quotient; hr = remainder; ht = control_signals_out;
            for (int c = 0; c < 5; c++) begin
               @(posedge clk); #1;
               n_total++;
               if (out_valid !== 1'b1 || in_ready !== 1'b0 || quotient !== hq || remainder !== hr || control_signals_out !== ht)
                  $display("FAIL b2b_hold_cycle%0d: got v=%b rdy=%b q=%h r=%h t=%h expected v=1 rdy=0 q=%h r=%h t=%h",
                           c, out_valid, in_ready, quotient, remainder, control_signals_out, hq, hr, ht);
               else n_pass++;
            end
         end
         release_result();
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_reset_mid_calc();
      test_mixed_signs();
      test_overflow();
      test_div_by_zero();
      test_back_to_back();
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

// File: doc/signed_divider.md
Name: signed_divider

Overview:
- Iterative signed divider producing quotient and remainder.
- Sits downstream of signed_multiplier in the FIR datapath and consumes its 2*WIDTH-bit product format, e.g. for gain normalisation.
- Carries a control-signal tag through alongside the operands, as the multiplier does.
- Uses valid/ready handshakes on both sides; one operation in flight at a time.

Parameters:
- WIDTH, 8, divisor and remainder width; dividend and quotient are 2*WIDTH.
- CONTROL_SIGNALS_WIDTH, 8, width of the tag carried with each operation.

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  synchronous, active-low reset.
- in_valid  in  1  operands valid.
- in_ready  out  1  block can accept an operation.
- dividend  in  2*WIDTH  signed dividend.
- divisor  in  WIDTH  signed divisor.
- control_signals_in  in  CONTROL_SIGNALS_WIDTH  tag captured with the operands.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts the result.
- quotient  out  2*WIDTH  signed quotient.
- remainder  out  WIDTH  signed remainder.
- overflow  out  1  quotient saturated: most-negative dividend divided by -1.
- div_by_zero  out  1  divisor was 0.
- control_signals_out  out  CONTROL_SIGNALS_WIDTH  tag of the current result.

Behaviour:
- Reset (rst==0 at a clk edge): state IDLE; in_ready=1; out_valid=0; quotient, remainder, overflow, div_by_zero and control_signals_out all 0. Reset wins over any handshake and aborts an operation in progress.
- Arithmetic:
  - Truncates toward zero; the remainder takes the dividend's sign; dividend == quotient*divisor + remainder.
  - |remainder| < |divisor|, so the remainder always fits WIDTH signed.
  - Internally: magnitudes, then a 2*WIDTH-step restoring shift-subtract, then sign fix.
- State machine:
  - IDLE: in_ready=1. On in_valid&&in_ready, latch the operands and tag. Divisor==0 goes to DONE; otherwise go to CALC with step counter=0.
  - CALC: in_ready=0. One quotient bit per cycle. After 2*WIDTH steps go to FIX.
  - FIX: one cycle. Apply signs, detect overflow, register outputs, go to DONE.
  - DONE: out_valid=1 and in_ready=0. On out_ready go to IDLE. Outputs hold stable while out_valid && !out_ready.
- Latency: out_valid rises 2*WIDTH+2 clock edges after the accepting edge (18 for WIDTH=8). Divide by zero takes 1 edge.
- Throughput: no new accept in the cycle out_valid drops, since in_ready is 1 only in IDLE. Minimum spacing between accepts is latency+1.
- Divide by zero: quotient = dividend>=0 ? +max : most-negative; remainder=0; div_by_zero=1; overflow=0.
- Overflow case: dividend = -2^(2*WIDTH-1) with divisor -1 gives quotient = 2^(2*WIDTH-1)-1, remainder 0, overflow=1.
- Flags and tag:
  - Flags are valid only with out_valid; they clear on the next accept.
  - control_signals_out updates only on leaving FIX or on a divide-by-zero DONE entry, and holds otherwise.
- Inputs other than in_valid are ignored outside the accepting edge.

Decomposition:
- Package signed_div_pkg:
  - State enum typedef (IDLE, CALC, FIX, DONE).
  - Step-counter width constant, $clog2(2*WIDTH)+1.
  - Function for the most-negative and most-positive constants.
- No sub-module. Magnitude, shift-subtract and sign fix live in one always_ff plus one always_comb.

Test Plan:
- Reset mid-CALC: accept 1000/7, hold rst=0 at edge 5 -> next edge in_ready=1, out_valid=0, all outputs 0, and no result ever appears.
- Basic, WIDTH=8: -1000/7 -> quotient -142, remainder -6, flags 0, out_valid exactly 18 edges after accept, tag 8'h05 echoed.
- Mixed signs: 32767/-128 -> quotient -255, remainder 127; -7/2 -> quotient -3, remainder -1.
- Overflow: -32768/-1 -> quotient 32767, remainder 0, overflow=1.
- Divide by zero: 100/0 -> quotient 32767, remainder 0, div_by_zero=1, out_valid 1 edge after accept; -5/0 -> quotient -32768.
- Backpressure: ten back-to-back ops with tags 1..10, out_ready held low 5 cycles on op 3 -> outputs stable while held, no op lost or reordered, in_ready=0 throughout DONE, all quotients match a reference model.
